// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin sharing of the DESim pixel-write port among four
// drawing requesters, plus a one-pixel-per-clock full-screen clear sweep.
module vga_plot_arbiter #(
   parameter int XW   = 8,
   parameter int YW   = 7,
   parameter int CW   = 24,
   parameter int XMAX = 160,
   parameter int YMAX = 120
) (
   input  logic            CLOCK_50,
   input  logic            reset,
   input  logic [3:0]      req,
   input  logic [4*XW-1:0] req_x,
   input  logic [4*YW-1:0] req_y,
   input  logic [4*CW-1:0] req_color,
   output logic [3:0]      grant,
   input  logic            clear_req,
   input  logic [CW-1:0]   clear_color,
   output logic            clear_busy,
   output logic            clear_done,
   output logic [XW-1:0]   VGA_X,
   output logic [YW-1:0]   VGA_Y,
   output logic [CW-1:0]   VGA_COLOR,
   output logic            plot
);

   localparam logic [XW-1:0] XLAST = XW'(XMAX - 1);
   localparam logic [YW-1:0] YLAST = YW'(YMAX - 1);

   typedef enum logic {SERVE, CLEAR} state_t;

   state_t        state, state_nxt;
   logic [1:0]    ptr, ptr_nxt;
   logic [XW-1:0] cx, cx_nxt;
   logic [YW-1:0] cy, cy_nxt;
   logic [CW-1:0] clr_col, clr_col_nxt;

   logic [XW-1:0] rx [4];
   logic [YW-1:0] ry [4];
   logic [CW-1:0] rc [4];

   logic [2:0]    win_p0;
   logic [XW-1:0] x_p0;
   logic [YW-1:0] y_p0;
   logic [CW-1:0] col_p0;
   logic          vld_p0;
   logic          done_p0;

   function automatic logic in_screen(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return (x <= XLAST) && (y <= YLAST);
   endfunction

   // Returns {found, index}; the smallest offset after p wins, offset 4 is p itself.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [2:0] pick;
      logic [1:0] idx;
      pick = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k + 1);
         if (r[idx]) pick = {1'b1, idx};
      end
      return pick;
   endfunction

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         rx[i] = req_x[i*XW +: XW];
         ry[i] = req_y[i*YW +: YW];
         rc[i] = req_color[i*CW +: CW];
      end
   end

   assign win_p0     = rr_pick(req, ptr);
   assign clear_busy = (state == CLEAR);

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      cx_nxt      = cx;
      cy_nxt      = cy;
      clr_col_nxt = clr_col;
      grant       = 4'b0000;
      x_p0        = VGA_X;
      y_p0        = VGA_Y;
      col_p0      = VGA_COLOR;
      vld_p0      = 1'b0;
      done_p0     = 1'b0;
      case (state)
         SERVE: begin
            if (clear_req) begin
               state_nxt   = CLEAR;
               clr_col_nxt = clear_color;
               cx_nxt      = '0;
               cy_nxt      = '0;
            end else if (win_p0[2]) begin
               grant   = 4'b0001 << win_p0[1:0];
               ptr_nxt = win_p0[1:0];
               x_p0    = rx[win_p0[1:0]];
               y_p0    = ry[win_p0[1:0]];
               col_p0  = rc[win_p0[1:0]];
               vld_p0  = in_screen(rx[win_p0[1:0]], ry[win_p0[1:0]]);
            end
         end
         CLEAR: begin
            x_p0   = cx;
            y_p0   = cy;
            col_p0 = clr_col;
            vld_p0 = 1'b1;
            if (cx == XLAST) begin
               cx_nxt = '0;
               if (cy == YLAST) begin
                  cy_nxt    = '0;
                  state_nxt = SERVE;
                  done_p0   = 1'b1;
               end else begin
                  cy_nxt = cy + 1'b1;
               end
            end else begin
               cx_nxt = cx + 1'b1;
            end
         end
         default: state_nxt = SERVE;
      endcase
   end

   // p0 -> output register stage
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state      <= SERVE;
         ptr        <= 2'd3;
         cx         <= '0;
         cy         <= '0;
         clr_col    <= '0;
         VGA_X      <= '0;
         VGA_Y      <= '0;
         VGA_COLOR  <= '0;
         plot       <= 1'b0;
         clear_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         cx         <= cx_nxt;
         cy         <= cy_nxt;
         clr_col    <= clr_col_nxt;
         VGA_X      <= x_p0;
         VGA_Y      <= y_p0;
         VGA_COLOR  <= col_p0;
         plot       <= vld_p0;
         clear_done <= done_p0;
      end
   end

endmodule
